// File: rtl/adc_lane_aligner.sv
// Multi-lane LVDS ADC deserializer that aligns the word boundary on a frame-lane pattern.
// It bit-slips until the frame lane matches, confirms lock, and then emits aligned words with loss-of-lock recovery.
module adc_lane_aligner #(
  parameter int               LANES         = 4,
  parameter int               WIDTH         = 14,
  parameter logic [WIDTH-1:0] FRAME_PATTERN = 14'h3F80,
  parameter int               LOCK_COUNT    = 4,
  parameter int               MISS_LIMIT    = 3
) (
  input  logic                   sys_clk,
  input  logic                   user_reset,
  input  logic [LANES-1:0]       lane_in,
  input  logic                   frame_in,
  input  logic                   relock,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic                   data_valid,
  output logic                   locked,
  output logic                   frame_err,
  output logic [7:0]             slip_count
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0]       MISS_N   = 4'(MISS_LIMIT);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_CHECK,
    S_LOCKED
  } state_e;

  state_e                       state_q, state_d;
  logic [LANES-1:0][WIDTH-1:0]  sr_q, sr_d;
  logic [WIDTH-1:0]             frame_sr_q, frame_sr_d;
  logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic                         blank_q, blank_d;
  logic [3:0]                   match_cnt_q, match_cnt_d;
  logic [3:0]                   miss_cnt_q, miss_cnt_d;
  logic [LANES*WIDTH-1:0]       data_out_q, data_out_d;
  logic                         data_valid_q, data_valid_d;
  logic                         frame_err_q, frame_err_d;
  logic [7:0]                   slip_count_q, slip_count_d;

  logic boundary;
  logic frame_match;
  logic slip;
  logic capture;
  logic miss;

  // The next shift-register contents are also the candidate words at a boundary.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sr_d[i] = {sr_q[i][WIDTH-2:0], lane_in[i]};
    end
    frame_sr_d = {frame_sr_q[WIDTH-2:0], frame_in};
  end

  // The hold cycle after a slip also sits at LAST_BIT, so blank masks it.
  assign boundary    = (bit_cnt_q == LAST_BIT) && !blank_q;
  assign frame_match = (frame_sr_d == FRAME_PATTERN);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    slip        = 1'b0;
    capture     = 1'b0;
    miss        = 1'b0;
    if (relock) begin
      state_d     = S_SEARCH;
      match_cnt_d = 4'd0;
      miss_cnt_d  = 4'd0;
    end else if (boundary) begin
      case (state_q)
        S_SEARCH: begin
          if (frame_match) begin
            match_cnt_d = 4'd1;
            if (LOCK_N <= 4'd1) begin
              state_d    = S_LOCKED;
              miss_cnt_d = 4'd0;
            end else begin
              state_d = S_CHECK;
            end
          end else begin
            slip = 1'b1;
          end
        end
        S_CHECK: begin
          if (frame_match) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q + 4'd1 >= LOCK_N) begin
              state_d    = S_LOCKED;
              miss_cnt_d = 4'd0;
            end
          end else begin
            state_d     = S_SEARCH;
            match_cnt_d = 4'd0;
            slip        = 1'b1;
          end
        end
        S_LOCKED: begin
          if (frame_match) begin
            capture    = 1'b1;
            miss_cnt_d = 4'd0;
          end else begin
            miss       = 1'b1;
            miss_cnt_d = miss_cnt_q + 4'd1;
            // Loss of lock restarts the search from the current boundary without slipping.
            if (miss_cnt_q + 4'd1 >= MISS_N) begin
              state_d     = S_SEARCH;
              match_cnt_d = 4'd0;
              miss_cnt_d  = 4'd0;
            end
          end
        end
        default: begin
          state_d = S_SEARCH;
        end
      endcase
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (!slip) begin
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
    end
    blank_d      = slip;
    slip_count_d = slip ? slip_count_q + 8'd1 : slip_count_q;
    data_out_d   = capture ? sr_d : data_out_q;
    data_valid_d = capture;
    frame_err_d  = miss;
  end

  always_ff @(posedge sys_clk or negedge user_reset) begin
    if (!user_reset) begin
      state_q      <= S_SEARCH;
      sr_q         <= '0;
      frame_sr_q   <= '0;
      bit_cnt_q    <= '0;
      blank_q      <= 1'b0;
      match_cnt_q  <= 4'd0;
      miss_cnt_q   <= 4'd0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      slip_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      frame_sr_q   <= frame_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      blank_q      <= blank_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      slip_count_q <= slip_count_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign locked     = (state_q == S_LOCKED);
  assign frame_err  = frame_err_q;
  assign slip_count = slip_count_q;

endmodule

// File: tb/tb_adc_lane_aligner.sv
// Directed bench for adc_lane_aligner: a 4x14 build and an 8x12 build.
// Lane i of word n carries n + (i << 8); the frame lane carries the pattern or a corrupted word.
module tb_adc_lane_aligner;

  localparam int LA = 4;
  localparam int WA = 14;
  localparam int LB = 8;
  localparam int WB = 12;

  logic             sys_clk = 1'b0;
  logic             user_reset = 1'b1;
  logic             relock = 1'b0;
  logic [LA-1:0]    lane_a = '0;
  logic             frame_a = 1'b0;
  logic [LB-1:0]    lane_b = '0;
  logic             frame_b = 1'b0;

  logic [LA*WA-1:0] data_out_a;
  logic             data_valid_a, locked_a, frame_err_a;
  logic [7:0]       slip_count_a;
  logic [LB*WB-1:0] data_out_b;
  logic             data_valid_b, locked_b, frame_err_b;
  logic [7:0]       slip_count_b;

  always #5 sys_clk = ~sys_clk;

  adc_lane_aligner #(
    .LANES(LA), .WIDTH(WA), .FRAME_PATTERN(14'h3F80), .LOCK_COUNT(4), .MISS_LIMIT(3)
  ) dut_a (
    .sys_clk(sys_clk), .user_reset(user_reset), .lane_in(lane_a), .frame_in(frame_a),
    .relock(relock), .data_out(data_out_a), .data_valid(data_valid_a), .locked(locked_a),
    .frame_err(frame_err_a), .slip_count(slip_count_a)
  );

  adc_lane_aligner #(
    .LANES(LB), .WIDTH(WB), .FRAME_PATTERN(12'hFC0), .LOCK_COUNT(4), .MISS_LIMIT(3)
  ) dut_b (
    .sys_clk(sys_clk), .user_reset(user_reset), .lane_in(lane_b), .frame_in(frame_b),
    .relock(relock), .data_out(data_out_b), .data_valid(data_valid_b), .locked(locked_b),
    .frame_err(frame_err_b), .slip_count(slip_count_b)
  );

  int          checks = 0;
  int          errors = 0;
  int          sel = 0;
  int          cyc = 0;
  int          dvCount, errPulses, lockDrops;
  int          lockRiseCyc, lockFallCyc, lastErrCyc, firstDvCyc;
  int          relockBit = -1;
  logic        prevLocked = 1'b0;
  logic        lockedAfterRelock = 1'b1;
  logic [15:0] firstLane [LB];
  logic [15:0] lastLane [LB];

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] laneWord(input int i);
    if (sel == 0) return 16'(data_out_a[i*WA +: WA]);
    return 16'(data_out_b[i*WB +: WB]);
  endfunction

  function automatic logic curLocked();
    return (sel == 0) ? locked_a : locked_b;
  endfunction

  function automatic logic [7:0] curSlip();
    return (sel == 0) ? slip_count_a : slip_count_b;
  endfunction

  task automatic clearCounters();
    dvCount     = 0;
    errPulses   = 0;
    lockDrops   = 0;
    lockRiseCyc = -1;
    lockFallCyc = -1;
    lastErrCyc  = -1;
    firstDvCyc  = -1;
    for (int i = 0; i < LB; i++) begin
      firstLane[i] = '0;
      lastLane[i]  = '0;
    end
  endtask

  // One serial bit on every lane, then sample the selected DUT 1 time unit after the edge.
  task automatic clockBit(input logic fbit, input logic [LB-1:0] lbits, input logic rl);
    logic dv, fe, lk;
    relock = rl;
    if (sel == 0) begin
      frame_a = fbit;
      lane_a  = lbits[LA-1:0];
    end else begin
      frame_b = fbit;
      lane_b  = lbits;
    end
    @(posedge sys_clk);
    #1;
    relock = 1'b0;
    cyc++;
    dv = (sel == 0) ? data_valid_a : data_valid_b;
    fe = (sel == 0) ? frame_err_a : frame_err_b;
    lk = curLocked();
    if (lk && !prevLocked) lockRiseCyc = cyc;
    if (!lk && prevLocked) begin
      lockFallCyc = cyc;
      lockDrops++;
    end
    if (rl) lockedAfterRelock = lk;
    prevLocked = lk;
    if (fe) begin
      errPulses++;
      lastErrCyc = cyc;
    end
    if (dv) begin
      dvCount++;
      for (int i = 0; i < ((sel == 0) ? LA : LB); i++) begin
        if (dvCount == 1) firstLane[i] = laneWord(i);
        lastLane[i] = laneWord(i);
      end
      if (dvCount == 1) firstDvCyc = cyc;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] fw, input int n);
    int w;
    int lanes;
    logic [LB-1:0] lb;
    logic [15:0] lw;
    w     = (sel == 0) ? WA : WB;
    lanes = (sel == 0) ? LA : LB;
    for (int k = 0; k < w; k++) begin
      lb = '0;
      for (int i = 0; i < lanes; i++) begin
        lw    = 16'(n + (i << 8));
        lb[i] = lw[w-1-k];
      end
      clockBit(fw[w-1-k], lb, k == relockBit);
    end
  endtask

  task automatic applyPad(input int nbits);
    for (int k = 0; k < nbits; k++) clockBit(1'b0, '0, 1'b0);
  endtask

  // Assert reset away from the clock edge, check outputs at once, release just after an edge.
  task automatic doReset();
    user_reset = 1'b0;
    relock     = 1'b0;
    frame_a    = 1'b0;
    lane_a     = '0;
    frame_b    = 1'b0;
    lane_b     = '0;
    #2;
    checkOutput("rst_data_a", longint'(|data_out_a), 0);
    checkOutput("rst_valid_a", longint'(data_valid_a), 0);
    checkOutput("rst_locked_a", longint'(locked_a), 0);
    checkOutput("rst_err_a", longint'(frame_err_a), 0);
    checkOutput("rst_slip_a", longint'(slip_count_a), 0);
    checkOutput("rst_data_b", longint'(|data_out_b), 0);
    checkOutput("rst_locked_b", longint'(locked_b), 0);
    repeat (2) @(posedge sys_clk);
    #1;
    user_reset = 1'b1;
    cyc        = 0;
    prevLocked = 1'b0;
    clearCounters();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    sel = 0;
    clearCounters();
    doReset();

    // Aligned stream: lock after the 4th boundary, first output is word 5.
    for (int n = 1; n <= 8; n++) applyStimulus(16'h3F80, n);
    checkOutput("t1_slip", longint'(curSlip()), 0);
    checkOutput("t1_lock_cyc", lockRiseCyc, 56);
    checkOutput("t1_dv_cyc", firstDvCyc, 70);
    checkOutput("t1_first_l0", firstLane[0], 16'h0005);
    checkOutput("t1_first_l3", firstLane[3], 16'h0305);
    checkOutput("t1_dv_cnt", dvCount, 4);
    checkOutput("t1_err_cnt", errPulses, 0);
    checkOutput("t1_last_l0", lastLane[0], 16'h0008);

    // Stream delayed 3 bits: three slips, then words from n=4 confirm lock.
    doReset();
    applyPad(3);
    for (int n = 1; n <= 10; n++) applyStimulus(16'h3F80, n);
    checkOutput("t2_slip", longint'(curSlip()), 3);
    checkOutput("t2_lock_cyc", lockRiseCyc, 101);
    checkOutput("t2_first_l0", firstLane[0], 16'h0008);
    checkOutput("t2_first_l1", firstLane[1], 16'h0108);
    checkOutput("t2_dv_cnt", dvCount, 3);
    checkOutput("t2_locked", longint'(curLocked()), 1);

    // Reset mid-word from a locked state with nonzero slip count and data.
    applyPad(7);
    doReset();

    // Single corrupted frame words while locked.
    for (int n = 1; n <= 6; n++) applyStimulus(16'h3F80, n);
    clearCounters();
    applyStimulus(16'h3F00, 7);
    checkOutput("t3_err1", errPulses, 1);
    checkOutput("t3_dv_sup", dvCount, 0);
    checkOutput("t3_hold_l0", laneWord(0), 16'h0006);
    checkOutput("t3_locked1", longint'(curLocked()), 1);
    applyStimulus(16'h3F80, 8);
    checkOutput("t3_dv_good", dvCount, 1);
    checkOutput("t3_good_l0", lastLane[0], 16'h0008);
    applyStimulus(16'h3F00, 9);
    applyStimulus(16'h3F00, 10);
    applyStimulus(16'h3F80, 11);
    checkOutput("t3_err3", errPulses, 3);
    checkOutput("t3_dv_cnt", dvCount, 2);
    checkOutput("t3_last_l0", lastLane[0], 16'h000B);
    checkOutput("t3_drops", lockDrops, 0);

    // Frame lane dead for 3 words: loss of lock, then relock without slips.
    doReset();
    for (int n = 1; n <= 6; n++) applyStimulus(16'h3F80, n);
    clearCounters();
    for (int n = 7; n <= 9; n++) applyStimulus(16'h0000, n);
    checkOutput("t4_err_cnt", errPulses, 3);
    checkOutput("t4_drops", lockDrops, 1);
    checkOutput("t4_fall_cyc", lockFallCyc, 126);
    checkOutput("t4_last_err", lastErrCyc, 126);
    checkOutput("t4_dv_none", dvCount, 0);
    for (int n = 10; n <= 15; n++) applyStimulus(16'h3F80, n);
    checkOutput("t4_relock_cyc", lockRiseCyc, 182);
    checkOutput("t4_slip", longint'(curSlip()), 0);
    checkOutput("t4_first_l0", firstLane[0], 16'h000E);
    checkOutput("t4_dv_cnt", dvCount, 2);

    // One-bit shift while in CHECK after two matches.
    doReset();
    applyStimulus(16'h3F80, 1);
    applyStimulus(16'h3F80, 2);
    applyPad(1);
    for (int n = 3; n <= 9; n++) applyStimulus(16'h3F80, n);
    checkOutput("t5_slip", longint'(curSlip()), 1);
    checkOutput("t5_lock_cyc", lockRiseCyc, 99);
    checkOutput("t5_drops", lockDrops, 0);
    checkOutput("t5_first_l0", firstLane[0], 16'h0008);
    checkOutput("t5_dv_cnt", dvCount, 2);

    // relock pulse mid-word while locked.
    doReset();
    for (int n = 1; n <= 6; n++) applyStimulus(16'h3F80, n);
    clearCounters();
    relockBit = 5;
    applyStimulus(16'h3F80, 7);
    relockBit = -1;
    for (int n = 8; n <= 12; n++) applyStimulus(16'h3F80, n);
    checkOutput("t6_locked_after", longint'(lockedAfterRelock), 0);
    checkOutput("t6_drops", lockDrops, 1);
    checkOutput("t6_relock_cyc", lockRiseCyc, 140);
    checkOutput("t6_slip", longint'(curSlip()), 0);
    checkOutput("t6_first_l0", firstLane[0], 16'h000B);
    checkOutput("t6_dv_cnt", dvCount, 2);

    // 8-lane, 12-bit build with the aligned stream.
    sel = 1;
    doReset();
    for (int n = 1; n <= 8; n++) applyStimulus(16'h0FC0, n);
    checkOutput("b_slip", longint'(curSlip()), 0);
    checkOutput("b_lock_cyc", lockRiseCyc, 48);
    checkOutput("b_dv_cyc", firstDvCyc, 60);
    checkOutput("b_first_l0", firstLane[0], 16'h0005);
    checkOutput("b_first_l7", firstLane[7], 16'h0705);
    checkOutput("b_dv_cnt", dvCount, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_lane_aligner.md
Name: adc_lane_aligner

Overview:
- Parametrised multi-lane serial-to-parallel deserializer for the LVDS ADC front end. Successor to the fixed 4-lane ADC deserializer.
- Captures LANES serial data bits plus the ADC frame-clock bit stream, one bit per lane per sys_clk cycle (bits already registered upstream).
- Finds the word boundary by bit-slipping until the frame lane matches FRAME_PATTERN.
- Confirms lock, then emits aligned WIDTH-bit words per lane, with loss-of-lock detection and automatic re-search.

Parameters:
- LANES, 4, number of serial data lanes (1..8)
- WIDTH, 14, bits per sample word (4..16)
- FRAME_PATTERN, 14'h3F80, expected frame-lane word at a correct boundary (WIDTH bits)
- LOCK_COUNT, 4, consecutive boundary matches required to declare lock (1..15)
- MISS_LIMIT, 3, consecutive boundary mismatches while locked that force re-search (1..15)

Ports:
- sys_clk  in  1  sole clock; all logic is rising-edge.
- user_reset  in  1  asynchronous, active-low reset.
- lane_in  in  LANES  serial data bits; bit i belongs to lane i.
- frame_in  in  1  serial frame-clock bit.
- relock  in  1  synchronous one-cycle pulse; forces SEARCH.
- data_out  out  LANES*WIDTH  aligned words; lane i is at [i*WIDTH +: WIDTH].
- data_valid  out  1  one-cycle strobe; data_out holds a new word.
- locked  out  1  high in LOCKED state.
- frame_err  out  1  one-cycle pulse on a frame mismatch while LOCKED.
- slip_count  out  8  total slips since reset; wraps 255->0.

Behaviour:
- Reset (user_reset=0, async):
  - data_out=0, data_valid=0, locked=0, frame_err=0, slip_count=0.
  - Shift registers cleared; bit_cnt=0; match_cnt=0; miss_cnt=0; blank=0.
  - State = SEARCH.
- Shift:
  - Every cycle, each lane register shifts MSB-first: sr <= {sr[WIDTH-2:0], in}. The frame lane shifts the same way.
  - word_next = {sr[WIDTH-2:0], in}. The first bit received ends up in the MSB.
- Counter:
  - bit_cnt advances 0..WIDTH-1 and wraps.
  - A boundary is the edge where bit_cnt==WIDTH-1. All comparisons use the frame lane's word_next at that edge.
- Slip:
  - bit_cnt holds at WIDTH-1 for one extra cycle, slip_count increments, and blank is set.
  - The next boundary is skipped while blank is set; blank then clears.
  - Consecutive evaluated boundaries are therefore WIDTH+1 cycles apart, and the window moves one bit later per slip.
- SEARCH:
  - Match at boundary: go to CHECK with match_cnt=1. If LOCK_COUNT==1, go straight to LOCKED.
  - Mismatch at boundary: slip.
- CHECK:
  - Match at boundary: match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED with miss_cnt=0.
  - Mismatch at boundary: go to SEARCH, match_cnt=0, and slip.
- LOCKED (locked=1):
  - Match at boundary: data_out <= word_next of every lane and data_valid=1 on the next cycle, so latency is 1 cycle after the edge that captures the LSB. miss_cnt=0.
  - Mismatch at boundary: data_valid stays 0, frame_err=1 for one cycle, miss_cnt++.
  - When miss_cnt reaches MISS_LIMIT: go to SEARCH, locked=0 on the next cycle, no slip on that transition.
  - data_out holds its last value outside strobes.
- relock:
  - From any state: next state SEARCH; match_cnt, miss_cnt and blank cleared; locked=0.
  - bit_cnt and slip_count are unaffected.
  - relock has priority over any boundary event in the same cycle.
- No data_valid is emitted in SEARCH or CHECK. The words that confirm lock are not output.
- Reset mid-operation returns all state to reset values immediately.

Test Plan:
1. Frame stream repeating 0x3F80 with its boundary aligned to bit_cnt, lanes carrying ramps 0x0001,0x0002,...:
   - No slips; slip_count=0.
   - locked rises 1 cycle after the 4th boundary, at cycle 4*WIDTH.
   - First data_valid word equals the lane ramp value of the 5th word.
2. Same streams delayed 3 bits:
   - Exactly 3 slips; slip_count=3.
   - locked after 4 matches.
   - data_out lane0 equals the transmitted word exactly, with no bit rotation.
3. Locked stream, then one frame word corrupted to 0x3F00:
   - One frame_err pulse; data_valid suppressed for that word; locked stays 1.
   - Next good word: data_valid=1 and miss_cnt cleared.
4. Locked stream, then frame lane forced to 0 for 3 words:
   - 3 frame_err pulses; locked falls after the 3rd.
   - Restoring 0x3F80: relock within 4 boundaries with no new slips.
5. Mismatch in CHECK after 2 matches (stream shifted 1 bit):
   - Returns to SEARCH; slip_count increments by 1.
   - Relock completes after 4 fresh matches.
6. Reset and control edge cases:
   - relock pulse while locked: locked=0 next cycle, re-lock without slips.
   - user_reset low mid-word: all outputs 0 immediately.
   - Parametrised build LANES=8, WIDTH=12, FRAME_PATTERN=12'hFC0 repeats scenario 1 with matching results.
